// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback
// over a shared memory port, with mem_ready wait states and illegal-instruction trapping.
module multi_cycle_controller #(
    parameter int ALU_CTRL_W      = 3,
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic                  zero,
    input  logic                  sign,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [2:0]            ImmSrc,
    output logic                  RegWrite,
    output logic                  illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRLINK, LUI, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);

    state_t state;
    logic   ready;
    logic   taken;
    logic   br_valid;
    logic   unused_func7;

    assign ready        = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic sub_sel);
        case (f3)
            3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    // blt/bge use the raw sign bit, so signed overflow is not corrected
    always_comb begin
        taken    = 1'b0;
        br_valid = 1'b1;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = sign;
            3'b101:  taken = ~sign;
            default: br_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:    if (ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_R:              state <= EXECR;
                        OP_I:              state <= EXECI;
                        OP_BR:             state <= BRANCH;
                        OP_JAL:            state <= JAL;
                        OP_JALR:           state <= JALR;
                        OP_LUI:            state <= LUI;
                        default: begin
                            state   <= ILLEGAL;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                MEMADR:   state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (ready) state <= MEMWB;
                MEMWRITE: if (ready) state <= FETCH;
                EXECR, EXECI, JAL, JALRLINK, LUI: state <= ALUWB;
                JALR:     state <= JALRLINK;
                BRANCH: begin
                    if (br_valid) begin
                        state <= FETCH;
                    end else begin
                        state   <= ILLEGAL;
                        illegal <= 1'b1;
                    end
                end
                ILLEGAL:  if (!TRAP_ON_ILLEGAL) state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op(func3, func7[5]);
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_op(func3, 1'b0);
            end
            ALUWB:    RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = br_valid & taken;
            end
            JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            JALRLINK: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
            LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
            default:  ;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE: ImmSrc = 3'b001;
            OP_BR:    ImmSrc = 3'b010;
            OP_JAL:   ImmSrc = 3'b011;
            OP_LUI:   ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end
endmodule
